pc_next_unit: RTL and testbench

//  Parametrised program-counter stage for the pipelined datapath.

---
 rtl/pc_next_unit.sv | 110 +++++++++++
 tb/tb_pc_next_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//   Program-counter stage for the pipelined datapath. Holds the architectural
//   PC, advances it by STEP each cycle, accepts jump/branch redirects (jump has
//   priority), freezes on stall and buffers a redirect that arrives during a
//   stall until the stall releases.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   stall        in   1      hold PC this cycle
//   jmp          in   1      jump redirect request (highest priority)
//   jmp_target   in   WIDTH  jump destination
//   br_taken     in   1      taken-branch redirect request
//   br_target    in   WIDTH  branch destination
//   pc_out       out  WIDTH  current PC (registered)
//   pc_plus_step out  WIDTH  pc_out + STEP (combinational, wraps)
//   pc_valid     out  1      low in reset and until the first edge after release
//   pend_valid   out  1      a redirect is buffered awaiting stall release
//   misalign     out  1      one-cycle pulse: a misaligned target was sampled
// -----------------------------------------------------------------------------
module pc_next_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter int unsigned      ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             pc_valid,
    output logic             pend_valid,
    output logic             misalign
);

    // Low-bit mask of the target; evaluates to zero when ALIGN_BITS is 0.
    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_valid_q, pend_valid_d;
    logic             misalign_q, misalign_d;
    logic             pc_valid_q;

    logic             redir;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] tgt_aligned;
    logic [WIDTH-1:0] pc_inc;

    assign redir       = jmp | br_taken;
    assign tgt         = jmp ? jmp_target : br_target;
    assign tgt_aligned = tgt & ~ALIGN_MASK;
    assign pc_inc      = pc_q + STEP_W;

    always_comb begin
        pc_d         = pc_q;
        pend_tgt_d   = pend_tgt_q;
        pend_valid_d = pend_valid_q;
        misalign_d   = 1'b0;

        // The first edge after reset release only raises pc_valid.
        if (pc_valid_q) begin
            misalign_d = redir && ((tgt & ALIGN_MASK) != '0);
            if (stall) begin
                if (redir) begin
                    pend_tgt_d   = tgt_aligned;
                    pend_valid_d = 1'b1;
                end
            end else if (redir) begin
                pc_d         = tgt_aligned;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                pc_d         = pend_tgt_q;
                pend_valid_d = 1'b0;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            pend_tgt_q   <= '0;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            pc_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= misalign_d;
            pc_valid_q   <= 1'b1;
        end
    end

    assign pc_out       = pc_q;
    assign pc_plus_step = pc_inc;
    assign pc_valid     = pc_valid_q;
    assign pend_valid   = pend_valid_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_next_unit
//   Directed bench for pc_next_unit with the default 32-bit, STEP=4,
//   RESET_VEC=0, ALIGN_BITS=2 configuration. Inputs change 1 time unit after
//   a rising edge and outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_step;
    logic        pc_valid;
    logic        pend_valid;
    logic        misalign;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_next_unit #(
        .WIDTH      (32),
        .STEP       (4),
        .RESET_VEC  (32'h0000_0000),
        .ALIGN_BITS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .pc_out       (pc_out),
        .pc_plus_step (pc_plus_step),
        .pc_valid     (pc_valid),
        .pend_valid   (pend_valid),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // T1: reset state, release, free run
        #3;
        check("rst_pc",        pc_out,             32'h0);
        check("rst_valid",     {31'b0, pc_valid},  32'h0);
        check("rst_pend",      {31'b0, pend_valid},32'h0);
        check("rst_misalign",  {31'b0, misalign},  32'h0);
        check("rst_plus",      pc_plus_step,       32'h4);
        step();
        rst = 1'b0;
        step();
        check("t1_first_pc",   pc_out,             32'h0);
        check("t1_first_valid",{31'b0, pc_valid},  32'h1);
        step(); check("t1_pc4",  pc_out, 32'h4);
        step(); check("t1_pc8",  pc_out, 32'h8);
        step(); check("t1_pc12", pc_out, 32'hC);
        check("t1_plus", pc_plus_step, 32'h10);

        // T2: wrap
        jmp = 1'b1; jmp_target = 32'hFFFF_FFF8;
        step(); check("t2_jmp", pc_out, 32'hFFFF_FFF8);
        check("t2_nomis", {31'b0, misalign}, 32'h0);
        jmp = 1'b0;
        step(); check("t2_fffc", pc_out, 32'hFFFF_FFFC);
        check("t2_plus_wrap", pc_plus_step, 32'h0);
        step(); check("t2_wrap0", pc_out, 32'h0);
        step(); check("t2_wrap4", pc_out, 32'h4);

        // T3: branch redirect
        jmp = 1'b1; jmp_target = 32'h10;
        step(); check("t3_pc10", pc_out, 32'h10);
        jmp = 1'b0; br_taken = 1'b1; br_target = 32'h200;
        step(); check("t3_br", pc_out, 32'h200);
        br_taken = 1'b0;
        step(); check("t3_br_next", pc_out, 32'h204);

        // T4: redirect buffered during stall
        stall = 1'b1;
        step(); check("t4_hold1", pc_out, 32'h204);
        check("t4_nopend", {31'b0, pend_valid}, 32'h0);
        br_taken = 1'b1; br_target = 32'h300;
        step(); check("t4_hold2", pc_out, 32'h204);
        check("t4_pend", {31'b0, pend_valid}, 32'h1);
        br_taken = 1'b0;
        step(); check("t4_hold3", pc_out, 32'h204);
        check("t4_pend_keep", {31'b0, pend_valid}, 32'h1);
        stall = 1'b0;
        step(); check("t4_apply", pc_out, 32'h300);
        check("t4_pend_clr", {31'b0, pend_valid}, 32'h0);
        step(); check("t4_next", pc_out, 32'h304);

        // T5: jump beats branch; misaligned target
        jmp = 1'b1; jmp_target = 32'h400; br_taken = 1'b1; br_target = 32'h500;
        step(); check("t5_jmp_wins", pc_out, 32'h400);
        br_taken = 1'b0; jmp_target = 32'h1002;
        step(); check("t5_aligned", pc_out, 32'h1000);
        check("t5_mis_on", {31'b0, misalign}, 32'h1);
        jmp = 1'b0;
        step(); check("t5_mis_next", pc_out, 32'h1004);
        check("t5_mis_off", {31'b0, misalign}, 32'h0);

        // New unstalled redirect wins over a pending one; overwrite of pending
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h700;
        step();
        br_target = 32'h710;
        step(); check("ov_hold", pc_out, 32'h1004);
        br_taken = 1'b0; stall = 1'b0;
        step(); check("ov_latest", pc_out, 32'h710);
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h720;
        step();
        br_taken = 1'b0; stall = 1'b0; jmp = 1'b1; jmp_target = 32'h800;
        step(); check("new_wins", pc_out, 32'h800);
        check("new_wins_pend", {31'b0, pend_valid}, 32'h0);
        jmp = 1'b0;
        step(); check("new_wins_next", pc_out, 32'h804);

        // T6: reset mid-stall discards pending
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h600;
        step(); check("t6_pend", {31'b0, pend_valid}, 32'h1);
        br_taken = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_async_pc",    pc_out,              32'h0);
        check("t6_async_pend",  {31'b0, pend_valid}, 32'h0);
        check("t6_async_valid", {31'b0, pc_valid},   32'h0);
        step();
        rst = 1'b0; stall = 1'b0;
        jmp = 1'b1; jmp_target = 32'h900;
        step(); check("t6_ignored", pc_out, 32'h0);
        check("t6_valid", {31'b0, pc_valid}, 32'h1);
        jmp = 1'b0;
        step(); check("t6_run4", pc_out, 32'h4);
        step(); check("t6_run8", pc_out, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
